// File: rtl/gpu_pkg.sv
// Shared definitions for the pixel-engine side of the GPU: requester
// indices, arbiter state encoding and the frame-buffer pixel width.
package gpu_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_BLA   = 0;
    localparam int REQ_FILL  = 1;
    localparam int REQ_ALPHA = 2;

    localparam int PIXEL_W   = 24;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Requester index to one-hot vector; out-of-range indices map to zero.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fb_mem_arbiter_rr_pick3.sv
// Three-way round-robin selector: searches last+1, last+2, last (mod 3)
// and returns the first requester found as a one-hot grant and an index.
module rr_pick3
    import gpu_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] ord0;
    logic [1:0] ord1;
    logic [1:0] ord2;

    // Rotate the search order so the most recent winner is checked last
    always_comb begin
        case (last)
            2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase

        found = 1'b1;
        if (|(req & idx_to_onehot(ord0))) begin
            idx = ord0;
        end else if (|(req & idx_to_onehot(ord1))) begin
            idx = ord1;
        end else if (|(req & idx_to_onehot(ord2))) begin
            idx = ord2;
        end else begin
            idx   = 2'd0;
            found = 1'b0;
        end

        gnt = found ? idx_to_onehot(idx) : 3'b000;
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer SRAM arbiter for the BLA, fill and alpha engines.
// Round-robin grant with an owner lock for read-modify-write, a registered
// SRAM command port and a fixed-latency tag pipeline that steers read
// returns back to the requester that issued them.
module fb_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = PIXEL_W,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [2:0]            lock,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    arb_state_t state;
    logic [1:0] last;
    logic [1:0] owner;

    logic [2:0] pick_gnt;
    logic [1:0] pick_idx;
    logic       pick_found;

    logic [1:0] gnt_idx;
    logic       gnt_any;
    logic       gnt_rd;

    // Read tag pipeline: stage 0 lines up with the registered command,
    // stage RD_LAT lines up with the SRAM read data.
    logic [RD_LAT:0]      tag_vld_p;
    logic [RD_LAT:0][1:0] tag_idx_p;

    rr_pick3 u_pick (
        .req   (req),
        .last  (last),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grant decode: round-robin while arbitrating, owner-only while locked
    always_comb begin
        gnt     = 3'b000;
        gnt_idx = pick_idx;
        gnt_any = 1'b0;
        if (!rst) begin
            if (state == ARB) begin
                gnt     = pick_gnt;
                gnt_any = pick_found;
            end else begin
                gnt_idx = owner;
                if (|(req & idx_to_onehot(owner))) begin
                    gnt     = idx_to_onehot(owner);
                    gnt_any = 1'b1;
                end
            end
        end
        gnt_rd = gnt_any && !we[gnt_idx];
    end

    // Arbiter FSM, round-robin pointer and registered SRAM command
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            last      <= 2'd2;
            owner     <= 2'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= gnt_any;
            if (gnt_any) begin
                mem_we    <= we[gnt_idx];
                mem_addr  <= addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                mem_wdata <= wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                last      <= gnt_idx;
            end
            case (state)
                ARB: begin
                    if (gnt_any && lock[gnt_idx]) begin
                        state <= LOCKED;
                        owner <= gnt_idx;
                    end
                end
                LOCKED: begin
                    if (gnt_any) begin
                        if (!lock[owner]) begin
                            state <= ARB;
                        end
                    end else if (!req[owner] && !lock[owner]) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Tag valid bits: cleared on reset so in-flight reads are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= gnt_rd;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
            end
        end
    end

    // Tag requester index travels beside its valid bit
    always_ff @(posedge clk) begin
        tag_idx_p[0] <= gnt_idx;
        for (int i = 1; i <= RD_LAT; i++) begin
            tag_idx_p[i] <= tag_idx_p[i-1];
        end
    end

    assign rvalid = tag_vld_p[RD_LAT] ? idx_to_onehot(tag_idx_p[RD_LAT]) : 3'b000;
    assign rdata  = mem_rdata;
    assign busy   = (state == LOCKED) || (|tag_vld_p);

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed scenarios followed by constrained
// random traffic, all scored against a transaction-level reference model.
module tb_fb_mem_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;
    localparam int RD_LAT = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          req, we, lock;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt, rvalid;
    logic [DATA_W-1:0]   rdata, mem_wdata, mem_rdata;
    logic                mem_en, mem_we, busy;
    logic [ADDR_W-1:0]   mem_addr;

    fb_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Contents of SRAM locations that were never written
    function automatic logic [23:0] dflt(input logic [18:0] a);
        logic [23:0] t;
        t = {5'd0, a} * 24'h001357;
        return t ^ 24'h5A5A5A;
    endfunction

    // ---------------- SRAM behavioural model ----------------
    logic [23:0] sram [logic [18:0]];
    logic [23:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] = mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ?
                      (sram.exists(mem_addr) ? sram[mem_addr] : dflt(mem_addr)) : 24'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    int          m_last, m_owner, m_gi;
    logic        exp_en, exp_we;
    logic [18:0] exp_addr;
    logic [23:0] exp_wdata;
    int          sched_idx [int];
    logic [23:0] sched_dat [int];
    logic [23:0] ref_mem [logic [18:0]];

    logic [2:0]  obs_gnt, obs_rvalid;
    logic [23:0] obs_rdata, obs_mem_wdata;
    logic [18:0] obs_mem_addr;
    logic        obs_busy, obs_mem_en, obs_mem_we;

    logic [2:0]  rr_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    function automatic logic [23:0] ref_rd(input logic [18:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic pending();
        foreach (sched_idx[k]) if (k >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        int ks[$];
        exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
        m_last = 2; m_owner = -1; m_gi = -1;
        foreach (sched_idx[k]) if (k > cyc) ks.push_back(k);
        foreach (ks[j]) begin
            sched_idx.delete(ks[j]);
            sched_dat.delete(ks[j]);
        end
    endtask

    // One clock cycle: score DUT outputs at the falling edge, then advance the model
    task automatic step();
        int gi, c;
        logic [2:0] eg, erv;
        logic [18:0] a;
        logic [23:0] d;
        @(negedge clk);
        gi = -1;
        if (!rst) begin
            if (m_owner >= 0) begin
                if (req[m_owner]) gi = m_owner;
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    c = (m_last + k) % 3;
                    if (gi < 0 && req[c]) gi = c;
                end
            end
        end
        eg = (gi >= 0) ? 3'(1 << gi) : 3'b000;
        obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata; obs_busy = busy;
        obs_mem_en = mem_en; obs_mem_we = mem_we; obs_mem_addr = mem_addr; obs_mem_wdata = mem_wdata;

        check("gnt", gnt, eg);
        check("mem_en", mem_en, exp_en);
        if (exp_en) check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_wdata);
        erv = sched_idx.exists(cyc) ? 3'(1 << sched_idx[cyc]) : 3'b000;
        check("rvalid", rvalid, erv);
        if (erv != 3'b000) check("rdata", rdata, sched_dat[cyc]);
        check("busy", busy, (m_owner >= 0) || pending());
        if (sched_idx.exists(cyc)) begin
            sched_idx.delete(cyc);
            sched_dat.delete(cyc);
        end

        m_gi = gi;
        if (rst) begin
            model_reset();
        end else if (gi >= 0) begin
            a = addr[gi*ADDR_W +: ADDR_W];
            d = wdata[gi*DATA_W +: DATA_W];
            exp_en = 1; exp_we = we[gi]; exp_addr = a; exp_wdata = d;
            if (we[gi]) begin
                ref_mem[a] = d;
            end else begin
                sched_idx[cyc+1+RD_LAT] = gi;
                sched_dat[cyc+1+RD_LAT] = ref_rd(a);
            end
            m_last = gi;
            if (m_owner < 0) begin
                if (lock[gi]) m_owner = gi;
            end else if (!lock[gi]) begin
                m_owner = -1;
            end
        end else begin
            exp_en = 0;
            if (m_owner >= 0 && !req[m_owner] && !lock[m_owner]) m_owner = -1;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic set_req(input int i, input logic r, input logic w, input logic l,
                           input logic [18:0] a, input logic [23:0] d);
        req[i] = r; we[i] = w; lock[i] = l;
        addr[i*ADDR_W +: ADDR_W]  = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        rst = 1; req = 0; we = 0; lock = 0; addr = '0; wdata = '0;
        for (int i = 0; i < 3; i++) set_req(i, 1, 1, 0, 19'(i + 1), 24'(32'hA0 + i));
        @(posedge clk); #1;
        model_reset();
        cyc = 1;

        // Reset held with every engine requesting
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_gnt", obs_gnt, 3'b000);
            check("rst_busy", obs_busy, 1'b0);
        end
        rst = 0;

        // Round-robin with all three writing
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_gnt", obs_gnt, rr_tab[k]);
        end
        req = 0;
        step();

        // BLA seeds the RMW location
        set_req(0, 1, 1, 0, 19'h2A000, 24'h123456);
        step();
        check("seed_gnt", obs_gnt, 3'b001);
        req = 0;
        step();

        // Single FILL write
        set_req(1, 1, 1, 0, 19'h00100, 24'hFF0000);
        step();
        check("wr_gnt", obs_gnt, 3'b010);
        req = 0;
        step();
        check("wr_mem_en", obs_mem_en, 1'b1);
        check("wr_mem_we", obs_mem_we, 1'b1);
        check("wr_mem_addr", obs_mem_addr, 19'h00100);
        check("wr_mem_wdata", obs_mem_wdata, 24'hFF0000);
        step();
        step();
        check("wr_no_rvalid", obs_rvalid, 3'b000);

        // Alpha read-modify-write under lock
        set_req(0, 1, 1, 0, 19'h5, 24'hAAAAAA);
        set_req(1, 1, 1, 0, 19'h6, 24'hBBBBBB);
        set_req(2, 1, 0, 1, 19'h2A000, 24'h0);
        step();
        check("rmw_gnt", obs_gnt, 3'b100);
        req[2] = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("rmw_block", obs_gnt, 3'b000);
        end
        check("rmw_rvalid", obs_rvalid, 3'b100);
        check("rmw_rdata", obs_rdata, 24'h123456);
        set_req(2, 1, 1, 0, 19'h2A000, 24'h654321);
        step();
        check("rmw_wr_gnt", obs_gnt, 3'b100);
        req[2] = 0;
        step();
        check("rmw_next_gnt", obs_gnt, 3'b001);
        req[0] = 0;
        step();
        check("rmw_fill_gnt", obs_gnt, 3'b010);
        req = 0;
        step();

        // BLA back-to-back reads
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1, 0, 0, 19'(32'h10 + k), 24'h0);
            step();
            check("rd_gnt", obs_gnt, 3'b001);
        end
        req = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rd_rvalid", obs_rvalid, 3'b001);
            check("rd_rdata", obs_rdata, dflt(19'(32'h10 + k)));
        end
        step();
        check("rd_drain", obs_rvalid, 3'b000);

        // Reset while a locked read is in flight
        set_req(0, 1, 0, 1, 19'h20, 24'h0);
        step();
        check("mr_gnt", obs_gnt, 3'b001);
        req[0] = 0;
        rst = 1;
        step();
        rst = 0;
        lock[0] = 0;
        set_req(1, 1, 1, 0, 19'h21, 24'h777777);
        step();
        check("mr_arb_gnt", obs_gnt, 3'b010);
        req = 0;
        step();
        check("mr_no_rvalid", obs_rvalid, 3'b000);
        check("mr_busy", obs_busy, 1'b0);

        // Random traffic obeying the hold-until-grant rule
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && m_gi != i && $urandom_range(0, 7) != 0) begin
                    // keep the pending request unchanged
                end else if (req[i] && m_gi != i) begin
                    req[i]  = 0;
                    lock[i] = ($urandom_range(0, 3) == 0);
                end else begin
                    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 3) == 0), 19'($urandom_range(0, 15)), 24'($urandom));
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;
        req = 0;
        lock = 0;
        for (int k = 0; k < 4; k++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
